// File: rtl/rgb_fade_pwm.sv
// Fades the current colour and brightness linearly toward an accepted target,
// then drives three brightness-scaled PWM outputs with glitch-free duty updates.
module rgb_fade_pwm #(
    parameter int unsigned STEP_DIV = 1024
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        tgt_valid,
    output logic        tgt_ready,
    input  logic [23:0] tgt_rgb,
    input  logic [7:0]  tgt_bright,
    input  logic        tgt_instant,
    output logic [23:0] cur_rgb,
    output logic [7:0]  cur_bright,
    output logic        busy,
    output logic        fade_done,
    output logic        pwm_r,
    output logic        pwm_g,
    output logic        pwm_b
);

    localparam logic [15:0] STEP_LAST = 16'(STEP_DIV - 1);
    localparam logic [7:0]  PWM_LAST  = 8'd254;

    typedef enum logic {IDLE, FADE} state_t;

    state_t state_q, state_d;

    // Byte lanes: [3]=R, [2]=G, [1]=B, [0]=brightness
    logic [3:0][7:0] cur_q, cur_d;
    logic [3:0][7:0] tgt_q, tgt_d;
    logic [3:0][7:0] req;
    logic [3:0][7:0] stepped;
    logic [15:0]     step_cnt_q, step_cnt_d;
    logic            fade_done_q, fade_done_d;
    logic [7:0]      pwm_cnt_q, pwm_cnt_d;
    logic [2:0][7:0] duty;
    logic [2:0][7:0] duty_act_q, duty_act_d;
    logic [2:0]      pwm_q, pwm_d;
    logic [15:0]     prod;
    logic            accept;
    logic            direct;
    logic            tick;
    logic            arrive;

    assign req    = {tgt_rgb, tgt_bright};
    assign accept = tgt_valid && tgt_ready;
    assign direct = tgt_instant || (req == cur_q);
    assign tick   = (step_cnt_q == STEP_LAST);
    assign arrive = tick && (stepped == tgt_q);

    always_comb begin
        stepped = cur_q;
        for (int i = 0; i < 4; i++) begin
            if (cur_q[i] < tgt_q[i]) begin
                stepped[i] = cur_q[i] + 8'd1;
            end else if (cur_q[i] > tgt_q[i]) begin
                stepped[i] = cur_q[i] - 8'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && !direct) state_d = FADE;
            FADE: if (arrive) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tgt_ready = (state_q == IDLE);
        busy      = (state_q == FADE);
    end

    always_comb begin
        cur_d       = cur_q;
        tgt_d       = tgt_q;
        step_cnt_d  = step_cnt_q;
        fade_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (direct) begin
                        cur_d       = req;
                        fade_done_d = 1'b1;
                    end else begin
                        tgt_d      = req;
                        step_cnt_d = 16'd0;
                    end
                end
            end
            FADE: begin
                step_cnt_d = tick ? 16'd0 : step_cnt_q + 16'd1;
                if (tick) begin
                    cur_d       = stepped;
                    fade_done_d = arrive;
                end
            end
            default: ;
        endcase
    end

    // Zero brightness must mean fully dark, so the scaled duty is forced to zero.
    always_comb begin
        duty = '0;
        prod = '0;
        for (int i = 0; i < 3; i++) begin
            prod = {8'd0, cur_q[i+1]} * ({8'd0, cur_q[0]} + 16'd1);
            duty[i] = (cur_q[0] == 8'd0) ? 8'd0 : 8'(prod >> 8);
        end
    end

    always_comb begin
        pwm_cnt_d  = (pwm_cnt_q == PWM_LAST) ? 8'd0 : pwm_cnt_q + 8'd1;
        duty_act_d = (pwm_cnt_q == PWM_LAST) ? duty : duty_act_q;
        for (int i = 0; i < 3; i++) begin
            pwm_d[i] = (pwm_cnt_q < duty_act_q[i]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur_q       <= '0;
            tgt_q       <= '0;
            step_cnt_q  <= '0;
            fade_done_q <= 1'b0;
            pwm_cnt_q   <= '0;
            duty_act_q  <= '0;
            pwm_q       <= '0;
        end else begin
            cur_q       <= cur_d;
            tgt_q       <= tgt_d;
            step_cnt_q  <= step_cnt_d;
            fade_done_q <= fade_done_d;
            pwm_cnt_q   <= pwm_cnt_d;
            duty_act_q  <= duty_act_d;
            pwm_q       <= pwm_d;
        end
    end

    assign cur_rgb    = cur_q[3:1];
    assign cur_bright = cur_q[0];
    assign fade_done  = fade_done_q;
    assign pwm_r      = pwm_q[2];
    assign pwm_g      = pwm_q[1];
    assign pwm_b      = pwm_q[0];

endmodule

// File: tb/tb_rgb_fade_pwm.sv
// Self-checking bench for rgb_fade_pwm: vector table of instant loads plus
// hand sequences and random fades checked against a closed-form fade model.
module tb_rgb_fade_pwm;

    localparam int STEP = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        tgt_valid = 1'b0;
    logic        tgt_ready;
    logic [23:0] tgt_rgb = '0;
    logic [7:0]  tgt_bright = '0;
    logic        tgt_instant = 1'b0;
    logic [23:0] cur_rgb;
    logic [7:0]  cur_bright;
    logic        busy;
    logic        fade_done;
    logic        pwm_r;
    logic        pwm_g;
    logic        pwm_b;

    int errors = 0;
    int checks = 0;

    // Model of the colour the DUT should currently hold
    logic [23:0] m_rgb = '0;
    logic [7:0]  m_br = '0;

    typedef struct {
        logic [23:0] rgb;
        logic [7:0]  br;
        int          er;
        int          eg;
        int          eb;
    } vec_t;

    vec_t vecs[6];

    rgb_fade_pwm #(.STEP_DIV(STEP)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .tgt_valid  (tgt_valid),
        .tgt_ready  (tgt_ready),
        .tgt_rgb    (tgt_rgb),
        .tgt_bright (tgt_bright),
        .tgt_instant(tgt_instant),
        .cur_rgb    (cur_rgb),
        .cur_bright (cur_bright),
        .busy       (busy),
        .fade_done  (fade_done),
        .pwm_r      (pwm_r),
        .pwm_g      (pwm_g),
        .pwm_b      (pwm_b)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Value of one byte n clocks after fade entry: moves one LSB every STEP clocks.
    function automatic logic [7:0] towards(input logic [7:0] s, input logic [7:0] t, input int n);
        int d;
        int st;
        d  = int'(t) - int'(s);
        st = n / STEP;
        if (d >= 0) return (d <= st) ? t : 8'(int'(s) + st);
        return (-d <= st) ? t : 8'(int'(s) - st);
    endfunction

    function automatic int expDuty(input logic [7:0] x, input logic [7:0] b);
        if (b == 8'd0) return 0;
        return ((int'(x) * (int'(b) + 1)) >> 8) & 255;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [23:0] rgb, input logic [7:0] br, input logic inst);
        @(negedge clock);
        tgt_valid   = 1'b1;
        tgt_rgb     = rgb;
        tgt_bright  = br;
        tgt_instant = inst;
        @(negedge clock);
        tgt_valid   = 1'b0;
        tgt_instant = 1'b0;
    endtask

    task automatic checkInstant(input string name, input logic [23:0] rgb, input logic [7:0] br);
        checkOutput({name, " load"}, {cur_rgb, cur_bright, busy, fade_done}, {rgb, br, 1'b0, 1'b1});
        @(negedge clock);
        checkOutput({name, " pulse"}, {busy, fade_done, tgt_ready}, {1'b0, 1'b0, 1'b1});
        m_rgb = rgb;
        m_br  = br;
    endtask

    task automatic trackFade(input string name, input logic [23:0] t_rgb, input logic [7:0] t_br,
                             input bit pulse_check, output int done_at);
        logic [31:0] s;
        logic [31:0] t;
        logic [31:0] e;
        int m;
        int d;
        int n;
        bit ok;
        s = {m_rgb, m_br};
        t = {t_rgb, t_br};
        m = 0;
        ok = 1'b1;
        done_at = -1;
        e = '0;
        for (int i = 0; i < 4; i++) begin
            d = int'(t[i*8 +: 8]) - int'(s[i*8 +: 8]);
            if (d < 0) d = -d;
            if (d > m) m = d;
        end
        for (int k = 1; k <= STEP * m + 20; k++) begin
            n = k - 1;
            if (ok && n <= STEP * m) begin
                for (int i = 0; i < 4; i++) e[i*8 +: 8] = towards(s[i*8 +: 8], t[i*8 +: 8], n);
                checks++;
                if ({cur_rgb, cur_bright, busy, tgt_ready, fade_done} !==
                    {e, n < STEP * m, n >= STEP * m, n == STEP * m}) begin
                    errors++;
                    ok = 1'b0;
                    $display("[TB] FAIL %s cycle %0d: got %h/%h busy=%b rdy=%b done=%b expected %h busy=%b",
                             name, n, cur_rgb, cur_bright, busy, tgt_ready, fade_done, e, n < STEP * m);
                end
            end
            if (fade_done === 1'b1) begin
                done_at = n;
                break;
            end
            @(negedge clock);
        end
        checkOutput({name, " duration"}, 64'(done_at), 64'(STEP * m));
        m_rgb = t_rgb;
        m_br  = t_br;
        if (pulse_check) begin
            @(negedge clock);
            checkOutput({name, " done pulse"}, {fade_done, busy, tgt_ready}, {1'b0, 1'b0, 1'b1});
        end
    endtask

    task automatic measurePwm(output int hr, output int hg, output int hb);
        hr = 0;
        hg = 0;
        hb = 0;
        repeat (260) @(negedge clock);
        repeat (255) begin
            @(negedge clock);
            hr += int'(pwm_r);
            hg += int'(pwm_g);
            hb += int'(pwm_b);
        end
    endtask

    initial begin
        int hr;
        int hg;
        int hb;
        int done_at;
        logic [23:0] rr;
        logic [7:0]  rb;
        logic        ri;
        int v;

        vecs[0] = '{24'hFF0000, 8'hFF, 255, 0, 0};
        vecs[1] = '{24'h808080, 8'h80, 64, 64, 64};
        vecs[2] = '{24'h102030, 8'hFF, 16, 32, 48};
        vecs[3] = '{24'hFF8001, 8'h01, 1, 1, 0};
        vecs[4] = '{24'h00FF00, 8'h00, 0, 0, 0};
        vecs[5] = '{24'hFFFFFF, 8'h00, 0, 0, 0};

        #3;
        checkOutput("reset hold", {cur_rgb, cur_bright, busy, fade_done, pwm_r, pwm_g, pwm_b, tgt_ready},
                    {32'd0, 6'd0, 1'b1});
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checkOutput("after release", {tgt_ready, busy, fade_done}, {1'b1, 1'b0, 1'b0});

        // Fade up from black
        applyStimulus(24'h008000, 8'h80, 1'b0);
        trackFade("fade up", 24'h008000, 8'h80, 1'b1, done_at);
        checkOutput("fade up 512", 64'(done_at), 64'd512);
        measurePwm(hr, hg, hb);
        checkOutput("fade up pwm", {32'(hr), 32'(hg)}, {32'd0, 32'd64});
        checkOutput("fade up pwm_b", 64'(hb), 64'd0);

        // Instant-load vector table
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].rgb, vecs[i].br, 1'b1);
            checkInstant($sformatf("vec%0d", i), vecs[i].rgb, vecs[i].br);
            measurePwm(hr, hg, hb);
            checkOutput($sformatf("vec%0d pwm_r", i), 64'(hr), 64'(vecs[i].er));
            checkOutput($sformatf("vec%0d pwm_g", i), 64'(hg), 64'(vecs[i].eg));
            checkOutput($sformatf("vec%0d pwm_b", i), 64'(hb), 64'(vecs[i].eb));
        end

        // Bright zero then fade to 1
        applyStimulus(24'hFFFFFF, 8'h01, 1'b0);
        trackFade("bright 01", 24'hFFFFFF, 8'h01, 1'b1, done_at);
        measurePwm(hr, hg, hb);
        checkOutput("bright 01 pwm", {16'(hr), 16'(hg), 16'(hb)}, {16'd1, 16'd1, 16'd1});

        // Mixed direction
        applyStimulus(24'hFF0000, 8'hFF, 1'b1);
        checkInstant("mixed start", 24'hFF0000, 8'hFF);
        applyStimulus(24'h0000FF, 8'hFF, 1'b0);
        trackFade("mixed", 24'h0000FF, 8'hFF, 1'b1, done_at);
        checkOutput("mixed 1020", 64'(done_at), 64'd1020);

        // Back-to-back with held valid
        @(negedge clock);
        tgt_valid  = 1'b1;
        tgt_rgb    = 24'h0004FA;
        tgt_bright = 8'hFC;
        @(negedge clock);
        tgt_rgb    = 24'h0302FA;
        tgt_bright = 8'hFC;
        trackFade("b2b first", 24'h0004FA, 8'hFC, 1'b0, done_at);
        @(negedge clock);
        checkOutput("b2b second accept", {busy, tgt_ready, cur_rgb, cur_bright}, {1'b1, 1'b0, 24'h0004FA, 8'hFC});
        tgt_valid = 1'b0;
        trackFade("b2b second", 24'h0302FA, 8'hFC, 1'b1, done_at);
        repeat (10) @(negedge clock);
        checkOutput("b2b no dup", {busy, fade_done, cur_rgb, cur_bright}, {2'b00, 24'h0302FA, 8'hFC});

        // Random fades and loads
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 3; i++) begin
                v = int'(m_rgb[i*8 +: 8]) + int'($urandom_range(0, 24)) - 12;
                if (v < 0) v = 0;
                if (v > 255) v = 255;
                rr[i*8 +: 8] = 8'(v);
            end
            v = int'(m_br) + int'($urandom_range(0, 24)) - 12;
            if (v < 0) v = 0;
            if (v > 255) v = 255;
            rb = 8'(v);
            ri = ($urandom_range(0, 3) == 0);
            applyStimulus(rr, rb, ri);
            if (ri || {rr, rb} == {m_rgb, m_br}) begin
                checkInstant($sformatf("rand%0d", r), rr, rb);
            end else begin
                trackFade($sformatf("rand%0d", r), rr, rb, 1'b1, done_at);
            end
        end
        measurePwm(hr, hg, hb);
        checkOutput("rand pwm",
                    {16'(hr), 16'(hg), 16'(hb)},
                    {16'(expDuty(m_rgb[23:16], m_br)), 16'(expDuty(m_rgb[15:8], m_br)),
                     16'(expDuty(m_rgb[7:0], m_br))});

        // Reset in the middle of a fade
        applyStimulus(24'hFFFFFF, 8'hFF, 1'b1);
        checkInstant("pre reset", 24'hFFFFFF, 8'hFF);
        repeat (300) @(negedge clock);
        applyStimulus(24'h000000, 8'h00, 1'b0);
        repeat (100) @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid-fade reset", {cur_rgb, cur_bright, busy, fade_done, pwm_r, pwm_g, pwm_b, tgt_ready},
                    {32'd0, 6'd0, 1'b1});
        @(negedge clock);
        reset_n = 1'b1;
        m_rgb = '0;
        m_br  = '0;
        @(negedge clock);
        checkOutput("reset release", {tgt_ready, busy, fade_done}, {1'b1, 1'b0, 1'b0});
        hr = 0;
        repeat (300) begin
            @(negedge clock);
            hr += int'(pwm_r) + int'(pwm_g) + int'(pwm_b) + int'(busy);
        end
        checkOutput("dark after reset", {32'(hr), cur_rgb, cur_bright}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
